multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath and PC width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 5, register-index width.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port instr  input  32  instruction word at address PC from instruction memory.
REQ-006 SHALL have port instr_valid  input  1  instr is valid this cycle.
REQ-007 SHALL have port eq  input  1  ALU Zero flag from the register/ALU datapath.
REQ-008 SHALL have port PC  output  DATA_WIDTH  address of the current instruction.
REQ-009 SHALL have ports rs1, rs2, rd  output  ADDRESS_WIDTH each  fields from the latched instruction register (IR).
REQ-010 SHALL have port ImmOp  output  DATA_WIDTH  sign-extended immediate for the IR type.
REQ-011 SHALL have ports RegWrite, ALUsrc, ResultSrc, MemWrite, jalmuxSel  output  1 each  datapath controls.
REQ-012 SHALL have port ALUCtrl  output  3  ALU operation: 000 add, 001 sub.
REQ-013 SHALL have port illegal  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-014 SHALL implement FSM states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK.
REQ-015 FETCH SHALL hold while instr_valid=0; with instr_valid=1 it SHALL latch instr into IR and go to DECODE.
REQ-016 DECODE SHALL go to WRITEBACK for jal, to FETCH with illegal=1 and PC+4 for unsupported opcodes, else to EXECUTE.
REQ-017 Supported opcodes SHALL be add (0110011/f3 000/f7 0000000), sub (0110011/f7 0100000), addi (0010011/000), lw (0000011/010), sw (0100011/010), beq (1100011/000), bne (1100011/001), jal (1101111).
REQ-018 EXECUTE SHALL go to WRITEBACK for add/sub/addi, MEMORY for lw/sw, and FETCH for branches.
REQ-019 MEMORY SHALL go to WRITEBACK for lw and FETCH for sw.
REQ-020 WRITEBACK SHALL always go to FETCH.
REQ-021 Latency in cycles, instr_valid high: add/sub/addi 4, lw 5, sw 4, beq/bne 3, jal 3.
REQ-022 ALUsrc SHALL be 1 for addi/lw/sw and 0 otherwise; ALUCtrl SHALL be 001 for sub/beq/bne and 000 otherwise.
REQ-023 These controls SHALL be held constant from DECODE to instruction end.
REQ-024 MemWrite SHALL be 1 only in MEMORY for sw: exactly one cycle per sw.
REQ-025 RegWrite SHALL be 1 only in WRITEBACK, and SHALL be 0 there when rd=0.
REQ-026 ResultSrc SHALL be 1 only for lw; jalmuxSel SHALL be 1 only for jal.
REQ-027 A branch SHALL be taken when (beq and eq=1) or (bne and eq=0), with eq sampled in EXECUTE.
REQ-028 PC SHALL update once, on the last cycle of each instruction: PC+ImmOp for a taken branch or jal, else PC+4, modulo 2^DATA_WIDTH.
REQ-029 PC SHALL remain stable through WRITEBACK so the datapath's PC+4 link value is correct.
REQ-030 ImmOp SHALL be the I/S/B/J immediate per opcode, sign-extended with bit0=0 for B/J; it SHALL be 0 for R-type.
REQ-031 Outputs SHALL be registered or decoded from state and IR only, with no combinational path from instr to controls.

Reset
REQ-032 rst=1 SHALL immediately force state FETCH, PC=0 and IR=0.
REQ-033 While rst=1 all strobe outputs (RegWrite, MemWrite, illegal, jalmuxSel, ResultSrc, ALUsrc) SHALL be 0, and ALUCtrl SHALL be 000.
REQ-034 rst asserted mid-instruction SHALL abort the instruction with no pending RegWrite/MemWrite issued after release.
REQ-035 The first fetch SHALL occur from PC=0.

Structure
REQ-036 Package multicycle_pkg SHALL hold the state enum, opcode/funct constants and ALUCtrl encodings.
REQ-037 A combinational sub-module imm_gen (IR in, ImmOp out) SHALL produce the immediate; the FSM and PC register remain in multicycle_ctrl.

Verification
REQ-038 addi x1,x0,5 (0x00500093) at PC=0 -> RegWrite pulse in cycle 4, rd=1, ImmOp=5, ALUsrc=1, PC=4 afterwards.
REQ-039 sw x1,8(x0) then lw x2,8(x0) -> one MemWrite cycle in MEMORY; lw takes 5 cycles with ResultSrc=1 and RegWrite in WRITEBACK.
REQ-040 bne with eq=0, offset -8, at PC=0x10 -> PC=0x08 after 3 cycles, no RegWrite/MemWrite; with eq=1 -> PC=0x14.
REQ-041 jal x1,+16 at PC=0x20 -> jalmuxSel=1 and RegWrite in WRITEBACK, PC=0x30; jal x0 -> no RegWrite.
REQ-042 instr_valid held low 3 cycles in FETCH -> state and PC unchanged; opcode 0x7F -> illegal pulse, PC+4.
REQ-043 rst asserted in MEMORY of sw -> MemWrite=0 immediately, PC=0, state FETCH.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle controller: FSM states, RV32 opcode/funct
// fields, ALU operation codes and the instruction-class decoder.
package multicycle_pkg;

   localparam logic [2:0] ST_FETCH     = 3'd0;
   localparam logic [2:0] ST_DECODE    = 3'd1;
   localparam logic [2:0] ST_EXECUTE   = 3'd2;
   localparam logic [2:0] ST_MEMORY    = 3'd3;
   localparam logic [2:0] ST_WRITEBACK = 3'd4;

   typedef enum logic [2:0] {
      FETCH     = ST_FETCH,
      DECODE    = ST_DECODE,
      EXECUTE   = ST_EXECUTE,
      MEMORY    = ST_MEMORY,
      WRITEBACK = ST_WRITEBACK
   } state_e;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_LSW = 3'b010;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [6:0] F7_SUB = 7'b0100000;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   typedef struct packed {
      logic add;
      logic sub;
      logic addi;
      logic lw;
      logic sw;
      logic beq;
      logic bne;
      logic jal;
   } iclass_t;

   // One-hot class of a supported instruction; all zero means unsupported.
   function automatic iclass_t decode(input logic [31:0] ir);
      iclass_t    c;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      op     = ir[6:0];
      f3     = ir[14:12];
      f7     = ir[31:25];
      c.add  = (op == OP_RTYPE) && (f3 == F3_ADD) && (f7 == F7_ADD);
      c.sub  = (op == OP_RTYPE) && (f3 == F3_ADD) && (f7 == F7_SUB);
      c.addi = (op == OP_IMM) && (f3 == F3_ADD);
      c.lw   = (op == OP_LOAD) && (f3 == F3_LSW);
      c.sw   = (op == OP_STORE) && (f3 == F3_LSW);
      c.beq  = (op == OP_BRANCH) && (f3 == F3_BEQ);
      c.bne  = (op == OP_BRANCH) && (f3 == F3_BNE);
      c.jal  = (op == OP_JAL);
      return c;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_imm_gen.sv
// Immediate generator: sign-extended I/S/B/J immediate selected by the IR opcode,
// zero for R-type and anything else.
module imm_gen
   import multicycle_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [31:0]           i_ir,
   output logic [DATA_WIDTH-1:0] o_imm
);

   logic signed [31:0] w_imm32;

   always_comb begin
      case (i_ir[6:0])
         OP_IMM, OP_LOAD: w_imm32 = {{20{i_ir[31]}}, i_ir[31:20]};
         OP_STORE:        w_imm32 = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
         OP_BRANCH:       w_imm32 = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25],
                                     i_ir[11:8], 1'b0};
         OP_JAL:          w_imm32 = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20],
                                     i_ir[30:21], 1'b0};
         default:         w_imm32 = '0;
      endcase
   end

   // Signed cast keeps the sign when DATA_WIDTH exceeds 32.
   assign o_imm = DATA_WIDTH'(w_imm32);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset controller: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK FSM,
// instruction register and PC; all controls decode from state and IR only.
module multicycle_ctrl
   import multicycle_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              instr,
   input  logic                     instr_valid,
   input  logic                     eq,
   output logic [DATA_WIDTH-1:0]    PC,
   output logic [ADDRESS_WIDTH-1:0] rs1,
   output logic [ADDRESS_WIDTH-1:0] rs2,
   output logic [ADDRESS_WIDTH-1:0] rd,
   output logic [DATA_WIDTH-1:0]    ImmOp,
   output logic                     RegWrite,
   output logic                     ALUsrc,
   output logic                     ResultSrc,
   output logic                     MemWrite,
   output logic                     jalmuxSel,
   output logic [2:0]               ALUCtrl,
   output logic                     illegal
);

   state_e                r_state;
   state_e                w_next;
   logic [31:0]           r_ir;
   logic [DATA_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] w_imm;
   iclass_t               w_cls;
   logic                  w_legal;
   logic                  w_active;
   logic                  w_last;
   logic                  w_redirect;

   assign w_cls      = decode(r_ir);
   assign w_legal    = |w_cls;
   assign w_active   = (r_state != FETCH);
   // Branches only finish in EXECUTE and jal only in WRITEBACK, so eq is seen there.
   assign w_redirect = w_cls.jal || (w_cls.beq && eq) || (w_cls.bne && !eq);
   assign w_last     = w_active && (w_next == FETCH);

   imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
      .i_ir  (r_ir),
      .o_imm (w_imm)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         FETCH:     if (instr_valid) w_next = DECODE;
         DECODE: begin
            if (!w_legal)      w_next = FETCH;
            else if (w_cls.jal) w_next = WRITEBACK;
            else               w_next = EXECUTE;
         end
         EXECUTE: begin
            if (w_cls.lw || w_cls.sw)        w_next = MEMORY;
            else if (w_cls.beq || w_cls.bne) w_next = FETCH;
            else                             w_next = WRITEBACK;
         end
         MEMORY:    w_next = w_cls.lw ? WRITEBACK : FETCH;
         WRITEBACK: w_next = FETCH;
         default:   w_next = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= FETCH;
         r_pc    <= '0;
         r_ir    <= '0;
      end else begin
         r_state <= w_next;
         if ((r_state == FETCH) && instr_valid) r_ir <= instr;
         if (w_last) r_pc <= w_redirect ? r_pc + w_imm : r_pc + DATA_WIDTH'(4);
      end
   end

   assign PC        = r_pc;
   assign ImmOp     = w_imm;
   assign rs1       = ADDRESS_WIDTH'(r_ir[19:15]);
   assign rs2       = ADDRESS_WIDTH'(r_ir[24:20]);
   assign rd        = ADDRESS_WIDTH'(r_ir[11:7]);
   // Gating with w_active keeps every control low in FETCH, hence during reset.
   assign RegWrite  = (r_state == WRITEBACK) && (r_ir[11:7] != 5'd0);
   assign MemWrite  = (r_state == MEMORY) && w_cls.sw;
   assign illegal   = (r_state == DECODE) && !w_legal;
   assign ALUsrc    = w_active && (w_cls.addi || w_cls.lw || w_cls.sw);
   assign ALUCtrl   = (w_active && (w_cls.sub || w_cls.beq || w_cls.bne)) ? ALU_SUB : ALU_ADD;
   assign ResultSrc = w_active && w_cls.lw;
   assign jalmuxSel = w_active && w_cls.jal;

endmodule
